// File: rtl/ad5791_cfg_sequencer_pkg.sv
// Shared constants for the AD5791 configuration sequencer: FSM encoding,
// DAC register addresses and status word layout.
package ad5791_cfg_sequencer_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned AXIS_W  = 3;

  // FSM state encoding (also exported through the status word)
  localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 4'd1;
  localparam logic [STATE_W-1:0] ST_ENTER     = 4'd2;
  localparam logic [STATE_W-1:0] ST_LOAD      = 4'd3;
  localparam logic [STATE_W-1:0] ST_SEND      = 4'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_DONE = 4'd5;
  localparam logic [STATE_W-1:0] ST_GUARD     = 4'd6;
  localparam logic [STATE_W-1:0] ST_EXIT      = 4'd7;

  // AD5791 register addresses (word bits 23:20)
  localparam logic [3:0] REG_DAC    = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_CLR    = 4'd3;
  localparam logic [3:0] REG_SWCTRL = 4'd4;

  // Status word field offsets
  localparam int unsigned STATUS_ERR_BIT   = 0;
  localparam int unsigned STATUS_AXIS_LSB  = 24;
  localparam int unsigned STATUS_WIDX_BIT  = 27;
  localparam int unsigned STATUS_STATE_LSB = 28;

  // Build a 24-bit AD5791 word from register address and 20-bit payload
  function automatic logic [23:0] ad5791_word(input logic [3:0] addr,
                                              input logic [19:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/ad5791_cfg_sequencer_if.sv
// Configuration port between the sequencer and the AD5791 SPI serializer.
interface ad5791_cfg_sequencer_if
  import ad5791_cfg_sequencer_pkg::*;
#(
  parameter int unsigned SAXIS_TDATA_WIDTH = 32
) ();

  logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata;
  logic                         M_AXISCFG_tvalid;
  logic                         configuration_mode;
  logic [AXIS_W-1:0]            configuration_axis;
  logic                         configuration_send;
  logic                         dac_ready;

  modport master (
    output M_AXISCFG_tdata,
    output M_AXISCFG_tvalid,
    output configuration_mode,
    output configuration_axis,
    output configuration_send,
    input  dac_ready
  );

  modport slave (
    input  M_AXISCFG_tdata,
    input  M_AXISCFG_tvalid,
    input  configuration_mode,
    input  configuration_axis,
    input  configuration_send,
    output dac_ready
  );

endinterface

// File: rtl/ad5791_wait_timer.sv
// Loadable down-counter shared by the guard and handshake-timeout waits.
module ad5791_wait_timer #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/ad5791_cfg_sequencer.sv
// Writes one or two configuration words into every AD5791 channel through
// the serializer's config port, then hands the serializer back to streaming.
module ad5791_cfg_sequencer
  import ad5791_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DAC           = 4,
  parameter int unsigned DAC_WORD_WIDTH    = 24,
  parameter int unsigned SAXIS_TDATA_WIDTH = 32,
  parameter int unsigned GUARD_CYCLES      = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 1024,
  parameter int unsigned CNT_W             = 11
) (
  input  logic                      a_clk,
  input  logic                      a_resetn,
  input  logic                      start,
  input  logic [DAC_WORD_WIDTH-1:0] cfg_word0,
  input  logic [DAC_WORD_WIDTH-1:0] cfg_word1,
  input  logic                      cfg_word1_en,
  ad5791_cfg_sequencer_if.master    cfg,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [31:0]               status
);

  localparam logic [AXIS_W-1:0] AXIS_LAST   = AXIS_W'(NUM_DAC - 1);
  localparam logic [CNT_W-1:0]  GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TOUT_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [STATE_W-1:0]           state_q, state_d;
  logic [DAC_WORD_WIDTH-1:0]    w0_q, w0_d, w1_q, w1_d;
  logic                         w1en_q, w1en_d;
  logic                         word_idx_q, word_idx_d;
  logic                         ph_q, ph_d;
  logic [AXIS_W-1:0]            axis_q, axis_d;
  logic [SAXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                         tvalid_q, tvalid_d;
  logic                         mode_q, mode_d;
  logic                         send_q, send_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         go_load_c;
  logic                         tmr_load_c;
  logic [CNT_W-1:0]             tmr_val_c;
  logic                         tmr_expired_c;
  logic [31:0]                  status_c;

  ad5791_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (a_clk),
    .rst_n     (a_resetn),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    w1en_d     = w1en_q;
    word_idx_d = word_idx_q;
    ph_d       = ph_q;
    axis_d     = axis_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    mode_d     = mode_q;
    send_d     = send_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    go_load_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w0_d       = cfg_word0;
          w1_d       = cfg_word1;
          w1en_d     = cfg_word1_en;
          word_idx_d = 1'b0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (cfg.dac_ready || tmr_expired_c) begin
          if (!cfg.dac_ready) err_d = 1'b1;
          mode_d  = 1'b1;
          state_d = ST_ENTER;
        end
      end
      ST_ENTER: begin
        if (tmr_expired_c) go_load_c = 1'b1;
      end
      ST_LOAD: begin
        // Phase A holds tvalid high; phase B drops it before axis moves on
        if (!ph_q) begin
          ph_d = 1'b1;
        end else if (axis_q == AXIS_LAST) begin
          send_d  = 1'b1;
          state_d = ST_SEND;
        end else begin
          axis_d   = axis_q + AXIS_W'(1);
          tvalid_d = 1'b1;
          ph_d     = 1'b0;
        end
      end
      ST_SEND: begin
        if (!cfg.dac_ready) begin
          send_d  = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (tmr_expired_c) begin
          send_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_GUARD;
        end
      end
      ST_WAIT_DONE: begin
        if (cfg.dac_ready || tmr_expired_c) begin
          if (!cfg.dac_ready) err_d = 1'b1;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (tmr_expired_c) begin
          if (!word_idx_q && w1en_q) begin
            word_idx_d = 1'b1;
            go_load_c  = 1'b1;
          end else begin
            mode_d  = 1'b0;
            state_d = ST_EXIT;
          end
        end
      end
      ST_EXIT: begin
        if (tmr_expired_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // First axis of a frame: word and axis appear together with tvalid
    if (go_load_c) begin
      state_d  = ST_LOAD;
      axis_d   = '0;
      ph_d     = 1'b0;
      tvalid_d = 1'b1;
      tdata_d  = SAXIS_TDATA_WIDTH'(word_idx_d ? w1_q : w0_q);
    end
  end

  // Restart the timer on every state change with the wait for the new state
  always_comb begin
    tmr_load_c = (state_d != state_q);
    tmr_val_c  = GUARD_LOAD;
    if (state_d == ST_WAIT_IDLE || state_d == ST_SEND || state_d == ST_WAIT_DONE) begin
      tmr_val_c = TOUT_LOAD;
    end
  end

  // State and output registers
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q    <= ST_IDLE;
      w0_q       <= '0;
      w1_q       <= '0;
      w1en_q     <= 1'b0;
      word_idx_q <= 1'b0;
      ph_q       <= 1'b0;
      axis_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      mode_q     <= 1'b0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w1en_q     <= w1en_d;
      word_idx_q <= word_idx_d;
      ph_q       <= ph_d;
      axis_q     <= axis_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      mode_q     <= mode_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Status word assembled from registered fields
  always_comb begin
    status_c = '0;
    status_c[STATUS_STATE_LSB +: STATE_W] = state_q;
    status_c[STATUS_WIDX_BIT]             = word_idx_q;
    status_c[STATUS_AXIS_LSB +: AXIS_W]   = axis_q;
    status_c[STATUS_ERR_BIT]              = err_q;
  end

  assign cfg.M_AXISCFG_tdata    = tdata_q;
  assign cfg.M_AXISCFG_tvalid   = tvalid_q;
  assign cfg.configuration_mode = mode_q;
  assign cfg.configuration_axis = axis_q;
  assign cfg.configuration_send = send_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign timeout_err            = err_q;
  assign status                 = status_c;

endmodule

// File: tb/tb_ad5791_cfg_sequencer.sv
// Directed bench for ad5791_cfg_sequencer with a small serializer model.
module tb_ad5791_cfg_sequencer;
  import ad5791_cfg_sequencer_pkg::*;

  logic        a_clk        = 1'b0;
  logic        a_resetn     = 1'b0;
  logic        start        = 1'b0;
  logic [23:0] cfg_word0    = '0;
  logic [23:0] cfg_word1    = '0;
  logic        cfg_word1_en = 1'b0;
  logic        busy, done, timeout_err;
  logic [31:0] status;

  ad5791_cfg_sequencer_if #(.SAXIS_TDATA_WIDTH(32)) cfg_if ();

  ad5791_cfg_sequencer dut (
    .a_clk        (a_clk),
    .a_resetn     (a_resetn),
    .start        (start),
    .cfg_word0    (cfg_word0),
    .cfg_word1    (cfg_word1),
    .cfg_word1_en (cfg_word1_en),
    .cfg          (cfg_if),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .status       (status)
  );

  always #4 a_clk = ~a_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Serializer model: drops ready for a few cycles on each armed send
  logic model_rdy     = 1'b1;
  logic armed         = 1'b1;
  int   busy_cnt      = 0;
  bit   model_respond = 1'b1;
  bit   stream_hold   = 1'b0;

  assign cfg_if.dac_ready = model_rdy & ~stream_hold;

  always @(posedge a_clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_rdy <= 1'b1;
    end else if (cfg_if.configuration_send && armed && model_respond) begin
      model_rdy <= 1'b0;
      busy_cnt  <= 8;
      armed     <= 1'b0;
    end
    if (!cfg_if.configuration_send) armed <= 1'b1;
  end

  // Monitor of the config port
  typedef struct packed {
    logic [2:0]  axis;
    logic [31:0] data;
  } pulse_t;

  pulse_t      pulses[$];
  int          send_rises = 0, mode_rises = 0, mode_falls = 0;
  int          lead_cnt = 0, lead_last = 0, tail_cnt = 0, tail_last = 0;
  int          send_hi = 0, send_last = 0;
  bit          lead_act = 1'b0, tail_act = 1'b0;
  logic        prev_mode = 1'b0, prev_send = 1'b0, prev_tvalid = 1'b0;
  logic [2:0]  prev_axis = '0;
  logic [31:0] prev_data = '0;

  always @(negedge a_clk) begin
    if (prev_tvalid && a_resetn) begin
      check("hold_axis", 32'(cfg_if.configuration_axis), 32'(prev_axis));
      check("hold_tdata", cfg_if.M_AXISCFG_tdata, prev_data);
    end
    if (cfg_if.M_AXISCFG_tvalid) pulses.push_back({cfg_if.configuration_axis, cfg_if.M_AXISCFG_tdata});
    if (cfg_if.configuration_send) send_hi = prev_send ? send_hi + 1 : 1;
    if (cfg_if.configuration_send && !prev_send) send_rises++;
    if (!cfg_if.configuration_send && prev_send) send_last = send_hi;
    if (cfg_if.configuration_mode && !prev_mode) begin
      mode_rises++;
      lead_act = 1'b1;
      lead_cnt = 0;
    end
    if (lead_act) begin
      if (cfg_if.M_AXISCFG_tvalid) begin
        lead_last = lead_cnt;
        lead_act  = 1'b0;
      end else begin
        lead_cnt++;
      end
    end
    if (!cfg_if.configuration_mode && prev_mode) begin
      mode_falls++;
      tail_act = 1'b1;
      tail_cnt = 0;
    end
    if (tail_act) begin
      if (busy) tail_cnt++;
      else begin
        tail_last = tail_cnt;
        tail_act  = 1'b0;
      end
    end
    prev_mode   = cfg_if.configuration_mode;
    prev_send   = cfg_if.configuration_send;
    prev_tvalid = cfg_if.M_AXISCFG_tvalid;
    prev_axis   = cfg_if.configuration_axis;
    prev_data   = cfg_if.M_AXISCFG_tdata;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(busy === 1'b0 && done === 1'b1) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_complete"}, 32'(n < budget), 32'd1);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int p0, sr0, mr0, mf0, n_found;
  logic [31:0] exp_data;

  initial begin
    // Reset state
    tick(3);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    32'(timeout_err), 32'd0);
    check("rst_mode",   32'(cfg_if.configuration_mode), 32'd0);
    check("rst_send",   32'(cfg_if.configuration_send), 32'd0);
    check("rst_tvalid", 32'(cfg_if.M_AXISCFG_tvalid), 32'd0);
    check("rst_tdata",  cfg_if.M_AXISCFG_tdata, 32'd0);
    check("rst_axis",   32'(cfg_if.configuration_axis), 32'd0);
    check("rst_status", status, 32'd0);
    a_resetn = 1'b1;
    tick(2);

    // One word, inputs changed after start and a second start while busy
    p0 = pulses.size(); sr0 = send_rises; mr0 = mode_rises; mf0 = mode_falls;
    cfg_word0 = ad5791_word(REG_CTRL, 20'h00012);
    cfg_word1 = ad5791_word(REG_CLR, 20'h00000);
    cfg_word1_en = 1'b0;
    pulse_start();
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_done_clr", 32'(done), 32'd0);
    cfg_word0 = 24'hABCDEF;
    cfg_word1_en = 1'b1;
    tick(5);
    pulse_start();
    wait_idle("s1", 400);
    check("s1_npulse", 32'(pulses.size() - p0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("s1_axis", 32'(pulses[p0 + i].axis), 32'(i));
      check("s1_tdata", pulses[p0 + i].data, 32'h0020_0012);
    end
    check("s1_sends", 32'(send_rises - sr0), 32'd1);
    check("s1_mode_rise", 32'(mode_rises - mr0), 32'd1);
    check("s1_mode_fall", 32'(mode_falls - mf0), 32'd1);
    check("s1_enter_guard", 32'(lead_last), 32'd16);
    check("s1_exit_guard", 32'(tail_last), 32'd16);
    check("s1_mode_end", 32'(cfg_if.configuration_mode), 32'd0);
    check("s1_err", 32'(timeout_err), 32'd0);
    check("s1_status", status, 32'h0300_0000);

    // Two words: control then clearcode, mode held across both frames
    p0 = pulses.size(); sr0 = send_rises; mr0 = mode_rises; mf0 = mode_falls;
    cfg_word0 = 24'h200012;
    cfg_word1 = 24'h300000;
    cfg_word1_en = 1'b1;
    pulse_start();
    cfg_word1 = 24'h123456;
    wait_idle("s2", 600);
    check("s2_npulse", 32'(pulses.size() - p0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_data = (i < 4) ? 32'h0020_0012 : 32'h0030_0000;
      check("s2_axis", 32'(pulses[p0 + i].axis), 32'(i % 4));
      check("s2_tdata", pulses[p0 + i].data, exp_data);
    end
    check("s2_sends", 32'(send_rises - sr0), 32'd2);
    check("s2_mode_rise", 32'(mode_rises - mr0), 32'd1);
    check("s2_mode_fall", 32'(mode_falls - mf0), 32'd1);
    check("s2_err", 32'(timeout_err), 32'd0);
    check("s2_status", status, 32'h0B00_0000);

    // Serializer never drops ready: send times out after 1024 cycles
    p0 = pulses.size(); sr0 = send_rises;
    model_respond = 1'b0;
    cfg_word1_en = 1'b0;
    pulse_start();
    wait_idle("s3", 3000);
    check("s3_err", 32'(timeout_err), 32'd1);
    check("s3_done", 32'(done), 32'd1);
    check("s3_mode", 32'(cfg_if.configuration_mode), 32'd0);
    check("s3_sends", 32'(send_rises - sr0), 32'd1);
    check("s3_send_len", 32'(send_last), 32'd1024);
    check("s3_npulse", 32'(pulses.size() - p0), 32'd4);
    check("s3_status", status, 32'h0300_0001);

    // Next start clears the sticky flags
    model_respond = 1'b1;
    pulse_start();
    tick(1);
    check("s3b_err_clr", 32'(timeout_err), 32'd0);
    check("s3b_done_clr", 32'(done), 32'd0);
    wait_idle("s3b", 400);
    check("s3b_err", 32'(timeout_err), 32'd0);

    // Start while a streaming frame is in flight
    p0 = pulses.size(); mr0 = mode_rises;
    stream_hold = 1'b1;
    pulse_start();
    tick(50);
    check("s4_mode_wait", 32'(cfg_if.configuration_mode), 32'd0);
    check("s4_busy_wait", 32'(busy), 32'd1);
    check("s4_state_wait", 32'(status[31:28]), 32'(ST_WAIT_IDLE));
    stream_hold = 1'b0;
    wait_idle("s4", 400);
    check("s4_err", 32'(timeout_err), 32'd0);
    check("s4_npulse", 32'(pulses.size() - p0), 32'd4);
    check("s4_mode_rise", 32'(mode_rises - mr0), 32'd1);
    check("s4_enter_guard", 32'(lead_last), 32'd16);

    // Reset during LOAD, then a full sequence afterwards
    pulse_start();
    n_found = 0;
    while (cfg_if.M_AXISCFG_tvalid !== 1'b1 && n_found < 200) begin
      tick(1);
      n_found++;
    end
    check("s5_reach_load", 32'(n_found < 200), 32'd1);
    a_resetn = 1'b0;
    #1;
    check("s5_rst_mode", 32'(cfg_if.configuration_mode), 32'd0);
    check("s5_rst_send", 32'(cfg_if.configuration_send), 32'd0);
    check("s5_rst_tvalid", 32'(cfg_if.M_AXISCFG_tvalid), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    tick(1);
    check("s5_rst_status", status, 32'd0);
    tick(2);
    a_resetn = 1'b1;
    tick(2);
    p0 = pulses.size();
    pulse_start();
    wait_idle("s5", 400);
    check("s5_npulse", 32'(pulses.size() - p0), 32'd4);
    check("s5_err", 32'(timeout_err), 32'd0);
    check("s5_mode", 32'(cfg_if.configuration_mode), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
